// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and requester ids for the memory arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10,
      ACK   = 2'b11
   } arb_state_e;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - CPU-first winner select with a starvation guard for the debug port
module mem_arb_prio
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic idle_i,
   input  logic cpu_req_i,
   input  logic dbg_req_i,
   input  logic grant_i,
   output logic winner_o
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [SW-1:0] starve_q, starve_d;

   assign winner_o = (dbg_req_i && (!cpu_req_i || starve_q == SW'(STARVE_MAX))) ? REQ_DBG : REQ_CPU;

   // Only CPU grants taken over a waiting debug request count towards starvation.
   always_comb begin
      starve_d = starve_q;
      if (idle_i && !dbg_req_i) begin
         starve_d = '0;
      end else if (grant_i) begin
         if (winner_o == REQ_DBG) begin
            starve_d = '0;
         end else if (starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises CPU and debug accesses onto one memory port with read latency
// Optional grant/conflict counters are built when MEM_ARBITER_PERF_EN is defined.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int READ_LAT   = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic          cclk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_ack,
   output logic [DW-1:0] dbg_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic [31:0]   cpu_grant_cnt,
   output logic [31:0]   dbg_grant_cnt,
   output logic [31:0]   conflict_cnt
);

   localparam int LW = $clog2(READ_LAT + 1);

   arb_state_e    state_q, state_d;
   logic          winner_q, winner_d;
   logic          we_q, we_d;
   logic [LW-1:0] lat_q, lat_d;
   logic          mem_en_q, mem_en_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          cpu_ack_q, cpu_ack_d;
   logic          dbg_ack_q, dbg_ack_d;
   logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
   logic          idle;
   logic          grant;
   logic          winner;

   assign idle = (state_q == IDLE);

   mem_arb_prio #(
      .STARVE_MAX(STARVE_MAX)
   ) u_prio (
      .clk_i    (cclk),
      .rst_i    (rst),
      .idle_i   (idle),
      .cpu_req_i(cpu_req),
      .dbg_req_i(dbg_req),
      .grant_i  (grant),
      .winner_o (winner)
   );

   // The memory address/data registers double as the latched request, so they are loaded at grant.
   always_comb begin
      state_d     = state_q;
      winner_d    = winner_q;
      we_d        = we_q;
      lat_d       = lat_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_ack_d   = 1'b0;
      dbg_ack_d   = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      dbg_rdata_d = dbg_rdata_q;
      grant       = 1'b0;
      case (state_q)
         IDLE: begin
            if (cpu_req || dbg_req) begin
               grant       = 1'b1;
               winner_d    = winner;
               we_d        = (winner == REQ_DBG) ? dbg_we : cpu_we;
               mem_en_d    = 1'b1;
               mem_we_d    = we_d;
               mem_addr_d  = (winner == REQ_DBG) ? dbg_addr : cpu_addr;
               mem_wdata_d = (winner == REQ_DBG) ? dbg_wdata : cpu_wdata;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            if (we_q) begin
               state_d   = ACK;
               cpu_ack_d = (winner_q == REQ_CPU);
               dbg_ack_d = (winner_q == REQ_DBG);
            end else begin
               state_d = WAIT;
               lat_d   = LW'(READ_LAT);
            end
         end
         WAIT: begin
            if (lat_q == LW'(1)) begin
               if (winner_q == REQ_CPU) begin
                  cpu_rdata_d = mem_rdata;
               end else begin
                  dbg_rdata_d = mem_rdata;
               end
               cpu_ack_d = (winner_q == REQ_CPU);
               dbg_ack_d = (winner_q == REQ_DBG);
               state_d   = ACK;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge cclk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         winner_q    <= REQ_CPU;
         we_q        <= 1'b0;
         lat_q       <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_ack_q   <= 1'b0;
         dbg_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         winner_q    <= winner_d;
         we_q        <= we_d;
         lat_q       <= lat_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_ack_q   <= cpu_ack_d;
         dbg_ack_q   <= dbg_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_ack   = cpu_ack_q;
   assign dbg_ack   = dbg_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dbg_rdata = dbg_rdata_q;
   assign busy      = !idle;

`ifdef MEM_ARBITER_PERF_EN
   logic [31:0] cpu_grant_cnt_q, dbg_grant_cnt_q, conflict_cnt_q;

   always_ff @(posedge cclk or posedge rst) begin
      if (rst) begin
         cpu_grant_cnt_q <= '0;
         dbg_grant_cnt_q <= '0;
         conflict_cnt_q  <= '0;
      end else begin
         if (grant && winner == REQ_CPU) cpu_grant_cnt_q <= cpu_grant_cnt_q + 32'd1;
         if (grant && winner == REQ_DBG) dbg_grant_cnt_q <= dbg_grant_cnt_q + 32'd1;
         if (idle && cpu_req && dbg_req) conflict_cnt_q <= conflict_cnt_q + 32'd1;
      end
   end

   assign cpu_grant_cnt = cpu_grant_cnt_q;
   assign dbg_grant_cnt = dbg_grant_cnt_q;
   assign conflict_cnt  = conflict_cnt_q;
`else
   assign cpu_grant_cnt = '0;
   assign dbg_grant_cnt = '0;
   assign conflict_cnt  = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized bench for mem_arbiter against a transaction-level reference model
module tb_mem_arbiter;

   parameter int READ_LAT   = 1;
   parameter int STARVE_MAX = 4;

   logic        cclk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic        dbg_req = 1'b0, dbg_we = 1'b0;
   logic [31:0] dbg_addr = '0, dbg_wdata = '0;
   logic [31:0] mem_rdata = '0;
   logic        cpu_ack, dbg_ack, mem_en, mem_we, busy;
   logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;
   logic [31:0] cpu_grant_cnt, dbg_grant_cnt, conflict_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   mem_arbiter #(.AW(32), .DW(32), .READ_LAT(READ_LAT), .STARVE_MAX(STARVE_MAX)) dut (
      .cclk(cclk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy),
      .cpu_grant_cnt(cpu_grant_cnt), .dbg_grant_cnt(dbg_grant_cnt), .conflict_cnt(conflict_cnt)
   );

   always #5 cclk = ~cclk;

   initial forever begin
      @(posedge cclk);
      cyc = cyc + 1;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] init_val(input logic [29:0] w);
      return {2'b00, w} * 32'h9E37_79B1;
   endfunction

   // Memory macro: word-indexed, read data valid READ_LAT cycles after the issue cycle, noise otherwise.
   logic [31:0] mac_mem [logic [29:0]];
   int          due_cyc = -1;
   logic [31:0] due_data;

   initial forever begin
      @(negedge cclk);
      if (mem_en && mem_we) mac_mem[mem_addr[31:2]] = mem_wdata;
      if (mem_en && !mem_we) begin
         due_cyc  = cyc + READ_LAT;
         due_data = mac_mem.exists(mem_addr[31:2]) ? mac_mem[mem_addr[31:2]] : init_val(mem_addr[31:2]);
      end
      mem_rdata = (cyc == due_cyc) ? due_data : $urandom;
   end

   // Reference model: one transaction at a time, timeline derived from the arbitration rules.
   logic [31:0] ref_mem [logic [29:0]];
   int          idle_from = 0, iss_cyc = -1, ack_cyc = -1, starve = 0;
   bit          iss_we, ack_port, ack_rd, w;
   logic [31:0] iss_addr, iss_wdata, ack_data;
   logic [31:0] n_cg = 0, n_dg = 0, n_conf = 0;
   bit          obs [$];

   initial forever begin
      @(negedge cclk);
      if (rst) begin
         idle_from = cyc + 1;
         iss_cyc   = -1;
         ack_cyc   = -1;
         starve    = 0;
         n_cg      = 0;
         n_dg      = 0;
         n_conf    = 0;
      end else begin
         check_eq("busy", busy, cyc < idle_from);
         check_eq("mem_en", mem_en, cyc == iss_cyc);
         if (cyc == iss_cyc) begin
            check_eq("mem_we", mem_we, iss_we);
            check_eq("mem_addr", mem_addr, iss_addr);
            if (iss_we) check_eq("mem_wdata", mem_wdata, iss_wdata);
         end
         check_eq("cpu_ack", cpu_ack, cyc == ack_cyc && ack_port == 1'b0);
         check_eq("dbg_ack", dbg_ack, cyc == ack_cyc && ack_port == 1'b1);
         if (cyc == ack_cyc && ack_rd)
            check_eq(ack_port ? "dbg_rdata" : "cpu_rdata", ack_port ? dbg_rdata : cpu_rdata, ack_data);
         if (cpu_ack) obs.push_back(1'b0);
         if (dbg_ack) obs.push_back(1'b1);
         if (cyc >= idle_from) begin
            if (cpu_req && dbg_req) n_conf++;
            if (cpu_req || dbg_req) begin
               w         = dbg_req && (!cpu_req || starve == STARVE_MAX);
               iss_we    = w ? dbg_we : cpu_we;
               iss_addr  = w ? dbg_addr : cpu_addr;
               iss_wdata = w ? dbg_wdata : cpu_wdata;
               if (w) begin
                  starve = 0;
                  n_dg++;
               end else begin
                  if (dbg_req && starve < STARVE_MAX) starve++;
                  n_cg++;
               end
               iss_cyc   = cyc + 1;
               ack_cyc   = iss_we ? cyc + 2 : cyc + 2 + READ_LAT;
               idle_from = ack_cyc + 1;
               ack_port  = w;
               ack_rd    = !iss_we;
               if (iss_we) ref_mem[iss_addr[31:2]] = iss_wdata;
               else ack_data = ref_mem.exists(iss_addr[31:2]) ? ref_mem[iss_addr[31:2]] : init_val(iss_addr[31:2]);
            end
            if (!dbg_req) starve = 0;
         end
      end
   end

   // One requester: n transactions, random idle gap, req dropped the cycle after its ack.
   task automatic master(input bit p, input int n, input int maxgap, input bit rnd,
                         input bit we0, input logic [31:0] a0, input logic [31:0] d0);
      for (int i = 0; i < n; i++) begin
         int  gap = (maxgap == 0) ? 0 : $urandom_range(0, maxgap);
         int  k = 0;
         bit  seen = 0;
         bit  we = rnd ? 1'($urandom_range(0, 1)) : we0;
         logic [31:0] a = rnd ? 32'($urandom_range(0, 63)) : a0;
         logic [31:0] d = rnd ? $urandom : d0;
         repeat (gap) begin
            @(posedge cclk);
            #1;
         end
         if (p) begin
            dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_req = 1'b1;
         end else begin
            cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
         end
         while (!seen && k < 400) begin
            @(negedge cclk);
            k++;
            seen = p ? dbg_ack : cpu_ack;
         end
         check_eq(p ? "dbg_ack_wait" : "cpu_ack_wait", seen, 1'b1);
         @(posedge cclk);
         #1;
         if (p) dbg_req = 1'b0;
         else cpu_req = 1'b0;
      end
   endtask

   task automatic settle();
      repeat (3) @(posedge cclk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      mac_mem[30'h4] = 32'hDEAD_BEEF;
      ref_mem[30'h4] = 32'hDEAD_BEEF;
      repeat (3) @(posedge cclk);
      @(negedge cclk);
      check_eq("rst_mem_en", mem_en, 0);
      check_eq("rst_mem_we", mem_we, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_mem_wdata", mem_wdata, 0);
      check_eq("rst_acks", {cpu_ack, dbg_ack}, 0);
      check_eq("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_cnts", {cpu_grant_cnt, dbg_grant_cnt} | conflict_cnt, 0);
      @(posedge cclk);
      #1 rst = 1'b0;

      @(posedge cclk);
      #1 cpu_addr = 32'h40; cpu_we = 1'b0; cpu_req = 1'b1;
      @(posedge cclk);
      #1;
      @(posedge cclk);
      #1 rst = 1'b1; cpu_req = 1'b0;
      @(negedge cclk);
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_mem_en", mem_en, 0);
      check_eq("midrst_cpu_ack", cpu_ack, 0);
      @(posedge cclk);
      #1 rst = 1'b0;
      settle();

      master(1'b0, 1, 0, 1'b0, 1'b0, 32'h10, 32'h0);
      settle();
      master(1'b1, 1, 0, 1'b0, 1'b1, 32'h20, 32'h1234_5678);
      settle();
      master(1'b1, 1, 0, 1'b0, 1'b0, 32'h20, 32'h0);
      settle();
      fork
         master(1'b0, 1, 0, 1'b0, 1'b1, 32'h30, 32'hAAAA_5555);
         master(1'b1, 1, 0, 1'b0, 1'b0, 32'h30, 32'h0);
      join
      settle();

      obs.delete();
      fork
         master(1'b0, 2 * STARVE_MAX, 0, 1'b1, 1'b0, 32'h0, 32'h0);
         master(1'b1, 2, 0, 1'b1, 1'b0, 32'h0, 32'h0);
      join
      check_eq("starve_len", obs.size(), 2 * (STARVE_MAX + 1));
      for (int i = 0; i < obs.size() && i < 2 * (STARVE_MAX + 1); i++)
         check_eq($sformatf("starve_order%0d", i), obs[i], (i % (STARVE_MAX + 1)) == STARVE_MAX);
      settle();

      fork
         master(1'b0, 40, 4, 1'b1, 1'b0, 32'h0, 32'h0);
         master(1'b1, 40, 4, 1'b1, 1'b0, 32'h0, 32'h0);
      join
      settle();
      @(negedge cclk);
`ifdef MEM_ARBITER_PERF_EN
      check_eq("cpu_grant_cnt", cpu_grant_cnt, n_cg);
      check_eq("dbg_grant_cnt", dbg_grant_cnt, n_dg);
      check_eq("conflict_cnt", conflict_cnt, n_conf);
`else
      check_eq("perf_tied_off", {cpu_grant_cnt, dbg_grant_cnt} | conflict_cnt, n_cg & 0);
`endif
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory port between two requesters: the multicycle CPU core (port 0, the IorD-muxed fetch/load/store path) and a debug/loader master (port 1).
- Serialises accesses and inserts the programmed read latency.
- Returns a one-cycle ack per transaction; the CPU control FSM stalls on it.
- Sits between the core/debug masters and the memory macro.

Parameters:
- AW, 32, address width (byte address; memory indexes words).
- DW, 32, data width.
- READ_LAT, 1, memory read latency in cycles (>=1). mem_rdata is valid READ_LAT cycles after the issue cycle.
- STARVE_MAX, 4, consecutive CPU grants allowed while dbg_req is pending before debug wins (>=1).

Ports:
- cclk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- cpu_req  in  1  CPU request; held stable until cpu_ack.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DW  read data; valid while cpu_ack=1.
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/AW/DW  debug request, same rules as CPU.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  DW  read data; valid while dbg_ack=1.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high in any state except IDLE.
- cpu_grant_cnt, dbg_grant_cnt, conflict_cnt  out  32 each  performance counters (see Optional Feature).

Behaviour:
- Reset (async, rst=1):
  - State=IDLE.
  - All outputs 0, rdata registers 0, starve counter 0.
  - An in-flight transaction is dropped with no ack. Memory may have been written if reset lands after ISSUE.
- FSM states: IDLE, ISSUE, WAIT, ACK.
  - IDLE: if cpu_req|dbg_req, pick winner; register winner id, we, addr, wdata; go to ISSUE. Otherwise stay.
  - ISSUE: mem_en=1; mem_we/mem_addr/mem_wdata from the registered request. Write: go to ACK. Read: go to WAIT, load latency counter with READ_LAT.
  - WAIT: decrement counter. On the cycle the counter reaches 1, capture mem_rdata into the winner's rdata register and go to ACK.
  - ACK: winner's ack=1 for exactly one cycle; go to IDLE.
- Memory outputs are registered. mem_en and mem_we are 0 outside ISSUE; mem_addr and mem_wdata hold their last value.
- Timing, with a request seen in IDLE at cycle t:
  - Write: ISSUE at t+1, ack at t+2.
  - Read: ISSUE at t+1, data sampled at t+1+READ_LAT, ack at t+2+READ_LAT.
- A requester deasserts req in the cycle after its ack. A req still high in the following IDLE is treated as a new request.
- Arbitration (evaluated in IDLE only):
  - Only one requesting: that one wins.
  - Both requesting: CPU wins unless starve counter == STARVE_MAX, in which case debug wins.
  - Starve counter increments on each CPU grant made while dbg_req=1, saturating at STARVE_MAX.
  - Starve counter clears on a debug grant, and in any IDLE cycle with dbg_req=0.
- Requests arriving during ISSUE/WAIT/ACK are not sampled until IDLE. The losing requester keeps req high and waits.
- cpu_rdata/dbg_rdata hold their last captured value outside ack; only the ack cycle is guaranteed valid.
- Addresses pass through unchanged; no alignment check.

Optional Feature:
- Macro MEM_ARBITER_PERF_EN.
- Defined:
  - cpu_grant_cnt, dbg_grant_cnt: increment on each grant.
  - conflict_cnt: increments each IDLE cycle in which both reqs are high.
  - All three are 32-bit, wrap at 2^32, and clear on rst.
- Undefined: the three ports exist but are tied to 0, and no counter flops are generated.

Decomposition:
- Package mem_arb_pkg holds:
  - State encoding localparams: IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, ACK=2'b11.
  - Requester id constants: REQ_CPU=1'b0, REQ_DBG=1'b1.
- Sub-module mem_arb_prio: combinational winner select plus the registered starve counter. Inputs: cpu_req, dbg_req, grant strobe. Output: winner id.
- The top level holds the FSM, the latency counter, the capture registers and the optional counters.

Test Plan:
- Reset: rst=1 pulsed mid-read (in WAIT) -> state IDLE immediately, mem_en=0, no cpu_ack afterwards, busy=0.
- CPU read, READ_LAT=1: cpu_req, addr 0x10, memory model returns 0xDEADBEEF -> mem_en pulse at t+1, cpu_ack at t+3 with cpu_rdata=0xDEADBEEF.
- Debug write: dbg_we=1, addr 0x20, wdata 0x12345678 -> single mem_en & mem_we cycle carrying that addr/data, dbg_ack at t+2, cpu_ack stays 0.
- Simultaneous single requests: both req high in one IDLE cycle, each dropping after its own ack -> CPU served first, debug served in the next IDLE, no overlap of mem_en.
- Starvation, STARVE_MAX=4: cpu_req and dbg_req held high continuously -> grant order C,C,C,C,D,C,C,C,C,D.
- READ_LAT=3 (separate build): read -> ack exactly 5 cycles after the IDLE sample cycle. With MEM_ARBITER_PERF_EN, conflict_cnt and both grant counters match the scoreboard.
